// File: rtl/mario_block_pkg.sv
// Shared tile codes and block engine FSM encoding.
// Used by the hit engine, renderer and level ROM.
package mario_block_pkg;

  localparam logic [5:0] B  = 6'd0;
  localparam logic [5:0] A  = 6'd1;
  localparam logic [5:0] C  = 6'd2;
  localparam logic [5:0] D  = 6'd3;
  localparam logic [5:0] E  = 6'd4;
  localparam logic [5:0] F  = 6'd5;
  localparam logic [5:0] G  = 6'd6;
  localparam logic [5:0] H  = 6'd7;
  localparam logic [5:0] I  = 6'd8;
  localparam logic [5:0] J  = 6'd9;
  localparam logic [5:0] K  = 6'd10;
  localparam logic [5:0] L  = 6'd11;
  localparam logic [5:0] M  = 6'd12;
  localparam logic [5:0] N  = 6'd13;
  localparam logic [5:0] O  = 6'd14;
  localparam logic [5:0] P  = 6'd15;
  localparam logic [5:0] Q  = 6'd16;
  localparam logic [5:0] R  = 6'd17;
  localparam logic [5:0] S  = 6'd18;
  localparam logic [5:0] T  = 6'd19;
  localparam logic [5:0] U  = 6'd20;
  localparam logic [5:0] V  = 6'd21;
  localparam logic [5:0] W  = 6'd22;
  localparam logic [5:0] X  = 6'd23;
  localparam logic [5:0] Y  = 6'd24;
  localparam logic [5:0] Z  = 6'd25;
  localparam logic [5:0] AY = 6'd26;
  localparam logic [5:0] IY = 6'd27;
  localparam logic [5:0] GY = 6'd28;
  localparam logic [5:0] KY = 6'd29;
  localparam logic [5:0] PY = 6'd30;
  localparam logic [5:0] TY = 6'd31;
  localparam logic [5:0] UY = 6'd32;
  localparam logic [5:0] WY = 6'd33;
  localparam logic [5:0] DY = 6'd34;
  localparam logic [5:0] BY = 6'd35;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WT,
    S_DEC,
    S_WR
  } state_t;

endpackage

// File: rtl/block_hit_rule.sv
// Hit rule: maps the struck tile code to its replacement.
// Pure combinational; no state.
module block_hit_rule
  import mario_block_pkg::*;
#(
  parameter int CODE_W = 6
) (
  input  logic [CODE_W-1:0] code,
  input  logic              in_side,
  input  logic              up,
  output logic              wr_en,
  output logic [CODE_W-1:0] wr_code,
  output logic              point
);

  // Question-block always yields; D and J need a side-on upward strike
  always_comb begin
    wr_en   = 1'b0;
    wr_code = '0;
    point   = 1'b0;
    unique case (1'b1)
      (code == CODE_W'(GY)): begin
        wr_en   = 1'b1;
        wr_code = CODE_W'(B);
        point   = 1'b1;
      end
      (code == CODE_W'(D) && in_side && up): begin
        wr_en   = 1'b1;
        wr_code = CODE_W'(DY);
        point   = 1'b1;
      end
      (code == CODE_W'(J) && in_side && up): begin
        wr_en   = 1'b1;
        wr_code = CODE_W'(B);
      end
      default: begin
        wr_en = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/block_hit_engine.sv
// Block hit engine: read-modify-write of the struck map tile,
// scoring and frame-timed bump animation.
module block_hit_engine
  import mario_block_pkg::*;
#(
  parameter int CODE_W      = 6,
  parameter int TILE_W      = 40,
  parameter int TILE_H      = 40,
  parameter int MAP_COLS    = 16,
  parameter int ADDR_W      = 10,
  parameter int BUMP_FRAMES = 8,
  parameter int SCORE_W     = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               hit_req,
  input  logic               up_direction,
  input  logic               direction,
  input  logic [9:0]         relative_xpos,
  input  logic [8:0]         relative_ypos,
  output logic [ADDR_W-1:0]  map_addr,
  input  logic [CODE_W-1:0]  map_rd_data,
  output logic [CODE_W-1:0]  map_wr_data,
  output logic               map_we,
  output logic               busy,
  output logic               new_point,
  output logic [SCORE_W-1:0] score,
  output logic               bump_active,
  output logic [ADDR_W-1:0]  bump_addr
);

  localparam int TMR_W = $clog2(BUMP_FRAMES + 1);

  state_t state;
  state_t state_nx;

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_in;
  logic [9:0]        x_q;
  logic              up_q;
  logic              dir_q;
  logic [CODE_W-1:0] code_q;
  logic [CODE_W-1:0] wcode_q;
  logic              point_q;
  logic [TMR_W-1:0]  timer;
  logic [31:0]       col;
  logic [31:0]       row;
  logic [31:0]       off;
  logic              in_side;
  logic              rule_we;
  logic [CODE_W-1:0] rule_code;
  logic              rule_pt;

  // Tile address from the contact point, side gate from latched x
  always_comb begin
    col     = 32'(relative_xpos) / 32'(TILE_W);
    row     = 32'(relative_ypos) / 32'(TILE_H);
    addr_in = ADDR_W'(row * 32'(MAP_COLS) + col);
    off     = 32'(x_q) % 32'(TILE_W);
    in_side = (off <  32'(TILE_W / 2) && !dir_q) ||
              (off >= 32'(TILE_W / 2) &&  dir_q);
  end

  block_hit_rule #(
    .CODE_W (CODE_W)
  ) u_rule (
    .code    (code_q),
    .in_side (in_side),
    .up      (up_q),
    .wr_en   (rule_we),
    .wr_code (rule_code),
    .point   (rule_pt)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next state and handshake outputs
  always_comb begin
    state_nx    = state;
    busy        = (state != S_IDLE);
    map_we      = (state == S_WR);
    new_point   = 1'b0;
    map_wr_data = '0;
    map_addr    = addr_q;
    bump_active = (timer != '0);
    unique case (state)
      S_IDLE: if (hit_req) state_nx = S_RD;
      S_RD:   state_nx = S_WT;
      S_WT:   state_nx = S_DEC;
      S_DEC:  state_nx = rule_we ? S_WR : S_IDLE;
      S_WR: begin
        state_nx    = S_IDLE;
        new_point   = point_q;
        map_wr_data = wcode_q;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Request latch, read capture and decision registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      x_q     <= '0;
      up_q    <= 1'b0;
      dir_q   <= 1'b0;
      code_q  <= '0;
      wcode_q <= '0;
      point_q <= 1'b0;
    end else begin
      if (state == S_IDLE && hit_req) begin
        addr_q <= addr_in;
        x_q    <= relative_xpos;
        up_q   <= up_direction;
        dir_q  <= direction;
      end
      if (state == S_WT) code_q <= map_rd_data;
      if (state == S_DEC) begin
        wcode_q <= rule_code;
        point_q <= rule_pt;
      end
    end
  end

  // Saturating point counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           score <= '0;
    else if (new_point && score != '1) score <= score + 1'b1;
  end

  // Bump timer: a write reloads and wins over a frame tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer     <= '0;
      bump_addr <= '0;
    end else if (map_we) begin
      timer     <= TMR_W'(BUMP_FRAMES);
      bump_addr <= addr_q;
    end else if (frame_tick && timer != '0) begin
      timer <= timer - 1'b1;
    end
  end

endmodule
